loop_trace_checker: RTL and testbench
=====================================

// Module: loop_trace_checker
// PURPOSE
//  Downstream monitor for the arithmetic loop core (outputs x, m, n). Samples the core's
//  per-cycle trace and checks the loop invariants for property mining:
//  C0 m<=x, C1 x<=n, C2 x steps by 0 or +1, C3 exit post-condition (n>0 -> m<n).
//  Produces sticky violation flags, per-check counts and a first-violation snapshot.
//  Sits beside the core in the simulation top; purely observational, never drives the core.
// PARAMETERS
//  W          11    width of x, m, n (unsigned)
//  CNT_W      16    width of cycle and violation counters
//  MAX_CYC    1000  RUN cycles before forced DONE
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  sample_en    in   1      trace valid this cycle; ignored unless in RUN
//  x            in   W      loop counter from core
//  m            in   W      tracked value from core
//  n            in   W      loop bound from core
//  viol         out  1      sticky: any check failed
//  viol_mask    out  4      sticky per-check flags, bit k = Ck
//  viol_cnt_k   out  CNT_W  per-check violation count, k=0..3, saturating
//  first_id     out  2      id of first failing check
//  first_cyc    out  CNT_W  RUN-cycle index of first failure
//  first_x/m/n  out  W      operand snapshot at first failure
//  cycles       out  CNT_W  sampled cycles so far
//  exited       out  1      loop exit seen (x==n)
//  done         out  1      checking finished
// BEHAVIOUR
//  - Reset: all outputs 0. State IDLE, prev_x_vld=0. Reset mid-run aborts with no residue.
//  - FSM IDLE -> RUN on first cycle after rst low.
//  - RUN -> DONE when cycles reaches MAX_CYC, or one cycle after C3 is evaluated.
//  - DONE holds until rst.
//  - RUN, sample_en=1: cycles++. C0, C1 evaluated combinationally on inputs, unsigned compare.
//  - C2 only when prev_x_vld. Legal iff x==prev_x or x==prev_x+1, computed at W+1 bits.
//  - Wrap 2^W-1 -> 0 is a C2 violation. prev_x <= x, prev_x_vld <= 1.
//  - Exit: first sample with x==n sets exited. C3 is evaluated that same cycle, once only.
//  - C3 passes when n==0.
//  - sample_en=0 in RUN: no checks, no counter or prev_x update.
//  - Violations are registered: flags, counts and snapshot visible the cycle after the failing sample.
//  - Simultaneous failures: all mask bits and counts update. first_id = lowest failing index.
//  - First snapshot written once, while viol==0.
//  - Counters saturate at 2^CNT_W-1, no wrap.
//  - cycles saturates and MAX_CYC still forces DONE.
//  - done=1 in DONE. Inputs are ignored in IDLE/DONE.
// STRUCTURE
//  - Shared pkg loop_chk_pkg: state enum {IDLE,RUN,DONE}; check ids C_M_LE_X=0, C_X_LE_N=1,
//    C_STEP=2, C_POST=3; NUM_CHECKS=4.
//  - Sub-module sat_counter #(CNT_W): clk, rst, inc -> q, saturating. 5 instances
//    (cycles, 4x viol_cnt).
//  - Top holds FSM, prev_x, exit detect, first-failure capture.
// TESTING
//  1. Clean trace n=5, x=0..5, m=x-1 per step (m=0 at x=0), sample_en=1
//     -> viol=0, exited at x=5, done 1 cycle later, cycles=6.
//  2. x jumps 3->5 -> viol_mask=0100, first_id=2, first_x=5, viol 1 cycle after the sample.
//  3. Same sample with m=7, x=4, n=3 (C0, C1, C2 fail) -> mask=0111, first_id=0,
//     counts 1,1,1,0.
//  4. n=4, exit with m=4, x=4 -> C3 fails, mask bit3=1, done next cycle.
//     Repeat with n=0 -> no C3 failure.
//  5. x=2047 then 0 -> C2 violation. Run MAX_CYC=1000 with no exit -> done at cycle 1000,
//     cycles=1000.
//  6. rst pulsed mid-RUN after violations -> all outputs 0 next cycle. sample_en low gaps
//     leave cycles and prev_x unchanged.

Source files
------------

// File: rtl/loop_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : loop_chk_pkg
// Brief   : Shared state encoding, check ids and helpers for the loop checker.
// Revision: 1.0
// ============================================================================
package loop_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         NUM_CHECKS = 4;
    localparam logic [1:0] C_M_LE_X   = 2'd0;
    localparam logic [1:0] C_X_LE_N   = 2'd1;
    localparam logic [1:0] C_STEP     = 2'd2;
    localparam logic [1:0] C_POST     = 2'd3;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [1:0] lowest_id(input logic [NUM_CHECKS-1:0] f);
        logic [1:0] id;
        id = 2'd0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (f[i]) id = 2'(i);
        end
        return id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/loop_trace_checker_if.sv
`default_nettype none
// ============================================================================
// Module  : loop_trace_checker_if
// Brief   : Trace inputs from the loop core and checker result outputs.
// Revision: 1.0
// ============================================================================
interface loop_trace_checker_if #(
    parameter int W     = 11,
    parameter int CNT_W = 16
);
    logic                                 sample_en;
    logic [W-1:0]                         x;
    logic [W-1:0]                         m;
    logic [W-1:0]                         n;

    logic                                 viol;
    logic [loop_chk_pkg::NUM_CHECKS-1:0]  viol_mask;
    logic [CNT_W-1:0]                     viol_cnt_0;
    logic [CNT_W-1:0]                     viol_cnt_1;
    logic [CNT_W-1:0]                     viol_cnt_2;
    logic [CNT_W-1:0]                     viol_cnt_3;
    logic [1:0]                           first_id;
    logic [CNT_W-1:0]                     first_cyc;
    logic [W-1:0]                         first_x;
    logic [W-1:0]                         first_m;
    logic [W-1:0]                         first_n;
    logic [CNT_W-1:0]                     cycles;
    logic                                 exited;
    logic                                 done;

    modport master (
        output sample_en, x, m, n,
        input  viol, viol_mask, viol_cnt_0, viol_cnt_1, viol_cnt_2, viol_cnt_3,
        input  first_id, first_cyc, first_x, first_m, first_n, cycles, exited, done
    );

    modport slave (
        input  sample_en, x, m, n,
        output viol, viol_mask, viol_cnt_0, viol_cnt_1, viol_cnt_2, viol_cnt_3,
        output first_id, first_cyc, first_x, first_m, first_n, cycles, exited, done
    );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that sticks at all-ones instead of wrapping.
// Revision: 1.0
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/loop_trace_checker.sv
`default_nettype none
// ============================================================================
// Module  : loop_trace_checker
// Brief   : Passive invariant monitor for the arithmetic loop core trace.
// Revision: 1.0
// ============================================================================
module loop_trace_checker
    import loop_chk_pkg::*;
#(
    parameter int W       = 11,
    parameter int CNT_W   = 16,
    parameter int MAX_CYC = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    loop_trace_checker_if.slave  tr
);

    localparam logic [31:0] C_CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0] C_LAST_RUN = 32'(MAX_CYC - 1);

    state_t                  r_state;
    logic [W-1:0]            r_prev_x;
    logic                    r_prev_vld;
    logic [31:0]             r_run_cyc;
    logic                    r_exited;
    logic                    r_done;
    logic                    r_viol;
    logic [NUM_CHECKS-1:0]   r_mask;
    logic [1:0]              r_first_id;
    logic [CNT_W-1:0]        r_first_cyc;
    logic [W-1:0]            r_first_x;
    logic [W-1:0]            r_first_m;
    logic [W-1:0]            r_first_n;

    logic                    w_sample;
    logic                    w_exit;
    logic [W:0]              w_prev_inc;
    logic [NUM_CHECKS-1:0]   w_fail;
    logic [NUM_CHECKS-1:0]   w_inc;
    logic [CNT_W-1:0]        w_cycles;
    logic [CNT_W-1:0]        w_viol_cnt [NUM_CHECKS];

    // Once the exit sample is taken, the remaining RUN cycle only retires the FSM.
    assign w_sample   = (r_state == RUN) && !r_exited && tr.sample_en;
    assign w_exit     = (tr.x == tr.n);
    assign w_prev_inc = {1'b0, r_prev_x} + {{W{1'b0}}, 1'b1};

    always_comb begin
        w_fail           = '0;
        w_fail[C_M_LE_X] = (tr.m > tr.x);
        w_fail[C_X_LE_N] = (tr.x > tr.n);
        w_fail[C_STEP]   = r_prev_vld && (tr.x != r_prev_x) && ({1'b0, tr.x} != w_prev_inc);
        w_fail[C_POST]   = w_exit && (tr.n != '0) && (tr.m >= tr.n);
    end

    assign w_inc = w_sample ? w_fail : '0;

    sat_counter #(.CNT_W(CNT_W)) u_cycles (
        .clk (clk),
        .rst (rst),
        .inc (w_sample),
        .q   (w_cycles)
    );

    generate
        for (genvar k = 0; k < NUM_CHECKS; k++) begin : g_viol_cnt
            sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (w_inc[k]),
                .q   (w_viol_cnt[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prev_x    <= '0;
            r_prev_vld  <= 1'b0;
            r_run_cyc   <= '0;
            r_exited    <= 1'b0;
            r_done      <= 1'b0;
            r_viol      <= 1'b0;
            r_mask      <= '0;
            r_first_id  <= '0;
            r_first_cyc <= '0;
            r_first_x   <= '0;
            r_first_m   <= '0;
            r_first_n   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_state   <= RUN;
                    r_run_cyc <= '0;
                end
                RUN: begin
                    if (r_exited) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        if (w_sample) begin
                            r_prev_x   <= tr.x;
                            r_prev_vld <= 1'b1;
                            if (w_exit) r_exited <= 1'b1;
                            if (|w_fail) begin
                                r_viol <= 1'b1;
                                r_mask <= r_mask | w_fail;
                                if (!r_viol) begin
                                    r_first_id  <= lowest_id(w_fail);
                                    r_first_cyc <= (r_run_cyc > C_CNT_MAX) ? '1 : r_run_cyc[CNT_W-1:0];
                                    r_first_x   <= tr.x;
                                    r_first_m   <= tr.m;
                                    r_first_n   <= tr.n;
                                end
                            end
                        end
                        r_run_cyc <= r_run_cyc + 32'd1;
                        if (r_run_cyc == C_LAST_RUN) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= DONE;
                end
            endcase
        end
    end

    assign tr.viol       = r_viol;
    assign tr.viol_mask  = r_mask;
    assign tr.viol_cnt_0 = w_viol_cnt[0];
    assign tr.viol_cnt_1 = w_viol_cnt[1];
    assign tr.viol_cnt_2 = w_viol_cnt[2];
    assign tr.viol_cnt_3 = w_viol_cnt[3];
    assign tr.first_id   = r_first_id;
    assign tr.first_cyc  = r_first_cyc;
    assign tr.first_x    = r_first_x;
    assign tr.first_m    = r_first_m;
    assign tr.first_n    = r_first_n;
    assign tr.cycles     = w_cycles;
    assign tr.exited     = r_exited;
    assign tr.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_loop_trace_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_loop_trace_checker
// Brief   : Directed and randomized trace checks against a reference model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_loop_trace_checker;

    localparam int W       = 11;
    localparam int CNT_W   = 16;
    localparam int MAX_CYC = 1000;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int XMAX    = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    loop_trace_checker_if #(.W(W), .CNT_W(CNT_W)) tr ();

    loop_trace_checker #(.W(W), .CNT_W(CNT_W), .MAX_CYC(MAX_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .tr  (tr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 running, 2 finished.
    int mp, mrun, mcyc, mprev, mfid, mfc, mfx, mfm, mfn, mmask;
    int mcnt [4];
    bit mpv, mviol, mexit;

    task automatic model_reset();
        mp = 0; mrun = 0; mcyc = 0; mprev = 0; mpv = 0; mviol = 0; mexit = 0;
        mfid = 0; mfc = 0; mfx = 0; mfm = 0; mfn = 0; mmask = 0;
        for (int k = 0; k < 4; k++) mcnt[k] = 0;
    endtask

    task automatic model_update(input bit r, input bit en, input int xv, input int mv, input int nv);
        int f [4];
        bit any;
        if (r) begin
            model_reset();
        end else if (mp == 0) begin
            mp = 1; mrun = 0;
        end else if (mp == 1) begin
            if (mexit) begin
                mp = 2;
            end else begin
                if (en) begin
                    mcyc = (mcyc < CMAX) ? mcyc + 1 : CMAX;
                    f[0] = int'(mv > xv);
                    f[1] = int'(xv > nv);
                    f[2] = int'(mpv && xv != mprev && xv != mprev + 1);
                    f[3] = int'(xv == nv && nv != 0 && !(mv < nv));
                    any = 0;
                    for (int k = 0; k < 4; k++) begin
                        if (f[k] != 0) begin
                            mcnt[k] = (mcnt[k] < CMAX) ? mcnt[k] + 1 : CMAX;
                            mmask = mmask | (1 << k);
                            if (!any && !mviol) begin
                                mfid = k; mfc = (mrun < CMAX) ? mrun : CMAX;
                                mfx = xv; mfm = mv; mfn = nv;
                            end
                            any = 1;
                        end
                    end
                    if (any) mviol = 1;
                    mprev = xv; mpv = 1;
                    if (xv == nv) mexit = 1;
                end
                mrun++;
                if (mrun == MAX_CYC) mp = 2;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("viol",      64'(tr.viol),       64'(mviol));
        chk("viol_mask", 64'(tr.viol_mask),  64'(mmask));
        chk("cnt0",      64'(tr.viol_cnt_0), 64'(mcnt[0]));
        chk("cnt1",      64'(tr.viol_cnt_1), 64'(mcnt[1]));
        chk("cnt2",      64'(tr.viol_cnt_2), 64'(mcnt[2]));
        chk("cnt3",      64'(tr.viol_cnt_3), 64'(mcnt[3]));
        chk("first_id",  64'(tr.first_id),   64'(mfid));
        chk("first_cyc", 64'(tr.first_cyc),  64'(mfc));
        chk("first_x",   64'(tr.first_x),    64'(mfx));
        chk("first_m",   64'(tr.first_m),    64'(mfm));
        chk("first_n",   64'(tr.first_n),    64'(mfn));
        chk("cycles",    64'(tr.cycles),     64'(mcyc));
        chk("exited",    64'(tr.exited),     64'(mexit));
        chk("done",      64'(tr.done),       64'(mp == 2));
    endtask

    task automatic step(input bit r, input bit en, input int xv, input int mv, input int nv);
        rst          = r;
        tr.sample_en = en;
        tr.x         = W'(xv & XMAX);
        tr.m         = W'(mv & XMAX);
        tr.n         = W'(nv & XMAX);
        @(posedge clk);
        model_update(r, en, xv & XMAX, mv & XMAX, nv & XMAX);
        #1;
        compare_all();
    endtask

    // Reset followed by the IDLE->RUN edge.
    task automatic restart();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        int xs, nv, mv, rst_at;
        bit en;
        model_reset();
        tr.sample_en = 1'b0; tr.x = '0; tr.m = '0; tr.n = '0;

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 1, 3, 7, 1);

        // Clean trace to exit at x=5
        step(0, 0, 0, 0, 0);
        for (int x = 0; x <= 5; x++) step(0, 1, x, (x > 0) ? x - 1 : 0, 5);
        chk("t1_done_not_yet", 64'(tr.done), 64'd0);
        step(0, 0, 0, 0, 0);
        chk("t1_viol", 64'(tr.viol), 64'd0);
        chk("t1_cycles", 64'(tr.cycles), 64'd6);
        chk("t1_done", 64'(tr.done), 64'd1);
        step(0, 1, 9, 9, 1);

        // Step jump 3 -> 5
        restart();
        for (int x = 0; x <= 3; x++) step(0, 1, x, 0, 10);
        step(0, 1, 5, 0, 10);
        chk("t2_mask", 64'(tr.viol_mask), 64'd4);
        chk("t2_first_id", 64'(tr.first_id), 64'd2);
        chk("t2_first_x", 64'(tr.first_x), 64'd5);

        // C0, C1, C2 on one sample
        restart();
        for (int x = 0; x <= 2; x++) step(0, 1, x, 0, 10);
        step(0, 1, 4, 7, 3);
        chk("t3_mask", 64'(tr.viol_mask), 64'd7);
        chk("t3_first_id", 64'(tr.first_id), 64'd0);

        // Exit post-condition, then n==0 exit
        restart();
        for (int x = 0; x <= 3; x++) step(0, 1, x, 0, 4);
        step(0, 1, 4, 4, 4);
        chk("t4_mask", 64'(tr.viol_mask), 64'd8);
        step(0, 0, 0, 0, 0);
        chk("t4_done", 64'(tr.done), 64'd1);
        restart();
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t4b_mask", 64'(tr.viol_mask), 64'd0);

        // Wrap 2047 -> 0, then run to MAX_CYC without exit
        restart();
        step(0, 1, XMAX, 0, 100);
        step(0, 1, 0, 0, 100);
        chk("t5_wrap", 64'((tr.viol_mask >> 2) & 1), 64'd1);
        xs = 0;
        for (int i = 0; i < MAX_CYC + 100 && mp != 2; i++) begin
            xs = xs + int'($urandom_range(0, 1));
            mv = int'($urandom_range(0, 40)) == 0 ? xs + 1 : int'($urandom_range(0, xs));
            step(0, 1, xs, mv, 2000);
        end
        chk("t5_done", 64'(tr.done), 64'd1);
        chk("t5_cycles", 64'(tr.cycles), 64'(MAX_CYC));

        // Randomized runs with sample gaps and a mid-run reset
        for (int run = 0; run < 6; run++) begin
            restart();
            xs = int'($urandom_range(0, 20));
            nv = xs + int'($urandom_range(3, 30));
            rst_at = int'($urandom_range(10, 50));
            for (int i = 0; i < 60; i++) begin
                if (i == rst_at && run % 2 == 0) begin
                    step(1, 1, xs, 0, nv);
                    chk("rst_viol", 64'(tr.viol), 64'd0);
                    chk("rst_cycles", 64'(tr.cycles), 64'd0);
                    step(0, 0, 0, 0, 0);
                end
                en = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 9))
                    0:       xs = int'($urandom_range(0, 40));
                    1, 2, 3: xs = xs;
                    default: xs = xs + 1;
                endcase
                mv = ($urandom_range(0, 7) == 0) ? xs + int'($urandom_range(1, 3))
                                                  : int'($urandom_range(0, xs));
                step(0, en, xs, mv, nv);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
